// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and fetch FSM state encoding for the CPU front end.
package cpu_pkg;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;
    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} fetch_state_t;
endpackage

// File: rtl/cpu_fetch_fifo.sv
// cpu_fetch_fifo: circular instruction buffer with synchronous flush.
module cpu_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = count == '0;
    assign full    = count == FULL_CNT;
    assign dout    = mem[rd_ptr];

    // Flush shares the reset path so it wins over any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst | flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/cpu_fetch.sv
// cpu_fetch: instruction fetch unit driving the memory controller fetch port,
// with wait handling, redirect/discard of in-flight accesses and a decode FIFO.
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0000,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fetch_en,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_re,
    input  logic [WORD_W-1:0] fetch_data_i,
    input  logic              fetch_wait_i,
    input  logic              mem_req_i,
    output logic              fetch_busy_o,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [WORD_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t      state, state_nx;
    logic [ADDR_W-1:0] pc, req_addr;
    logic              issue_ok, push, pop;
    logic              fifo_empty, fifo_full;
    logic [CW-1:0]     fifo_count;

    // Room is judged on the current count only; a same-cycle pop does not help.
    assign issue_ok = ~rst & ~mem_req_i & ~redirect_i & ~fifo_full;
    assign pop      = instr_ready_i & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (issue_ok & fetch_wait_i ? WAIT : IDLE)
                 : state == WAIT ? (~fetch_wait_i ? IDLE : redirect_i ? DISCARD : WAIT)
                 : (~fetch_wait_i ? IDLE : DISCARD);
    end

    always_comb begin
        fetch_en     = state == IDLE ? issue_ok : 1'b1;
        fetch_addr   = state == IDLE ? pc : req_addr;
        fetch_re     = fetch_en;
        fetch_busy_o = state != IDLE;
        push         = state == IDLE ? issue_ok & ~fetch_wait_i
                     : state == WAIT & ~fetch_wait_i & ~redirect_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            if (redirect_i) pc <= redirect_pc_i;
            else if (push)  pc <= pc + 1'b1;
            if (state == IDLE & issue_ok & fetch_wait_i) req_addr <= pc;
        end
    end

    cpu_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .din   ({fetch_addr, fetch_data_i}),
        .dout  ({instr_pc_o, instr_o}),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign instr_valid_o = fifo_count != '0;
endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: directed self-checking bench for the instruction fetch unit.
module tb_cpu_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en, fetch_re, fetch_busy_o, instr_valid_o;
    logic [15:0] fetch_addr, fetch_data_i, instr_o, instr_pc_o;
    logic        fetch_wait_i, mem_req_i, redirect_i, instr_ready_i;
    logic [15:0] redirect_pc_i;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign fetch_data_i = fetch_addr ^ 16'hA5A5;

    cpu_fetch #(.RESET_PC(16'h0000), .FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .fetch_addr    (fetch_addr),
        .fetch_re      (fetch_re),
        .fetch_data_i  (fetch_data_i),
        .fetch_wait_i  (fetch_wait_i),
        .mem_req_i     (mem_req_i),
        .fetch_busy_o  (fetch_busy_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i)
    );

    logic        bp_ready [7] = '{0, 0, 0, 0, 1, 1, 1};
    logic        bp_en    [7] = '{1, 1, 0, 0, 0, 1, 1};
    logic [15:0] bp_addr  [7] = '{0, 1, 2, 2, 2, 2, 3};
    logic        bp_valid [7] = '{0, 1, 1, 1, 1, 1, 1};
    logic [15:0] bp_hpc   [7] = '{0, 0, 0, 0, 0, 1, 2};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        mem_req_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 16'h0000;
        fetch_wait_i = 1'b0;
        instr_ready_i = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_stream(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mem_req_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 16'h0000;
        fetch_wait_i = 1'b0;
        instr_ready_i = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if ({fetch_en, fetch_re, fetch_busy_o, instr_valid_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got en/re/busy/valid=%b required 0000",
                     {fetch_en, fetch_re, fetch_busy_o, instr_valid_o});
        end
        checks++;
        if (fetch_addr !== 16'h0000) begin
            failures++;
            $display("FAIL reset_addr got %h required 0000", fetch_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (fetch_en !== 1'b1 || fetch_re !== 1'b1 || fetch_addr !== 16'(i)) begin
                failures++;
                $display("FAIL stream_issue i=%0d got en=%b re=%b addr=%h required en=1 re=1 addr=%h",
                         i, fetch_en, fetch_re, fetch_addr, 16'(i));
            end
            if (i > 0) begin
                checks++;
                if (instr_valid_o !== 1'b1 || instr_pc_o !== 16'(i - 1) ||
                    instr_o !== (16'(i - 1) ^ 16'hA5A5)) begin
                    failures++;
                    $display("FAIL stream_head i=%0d got valid=%b pc=%h instr=%h required 1 %h %h",
                             i, instr_valid_o, instr_pc_o, instr_o, 16'(i - 1), 16'(i - 1) ^ 16'hA5A5);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            instr_ready_i = bp_ready[c];
            #1;
            checks++;
            if (fetch_en !== bp_en[c] || fetch_addr !== bp_addr[c] || instr_valid_o !== bp_valid[c]) begin
                failures++;
                $display("FAIL bp_ctrl c=%0d got en=%b addr=%h valid=%b required en=%b addr=%h valid=%b",
                         c, fetch_en, fetch_addr, instr_valid_o, bp_en[c], bp_addr[c], bp_valid[c]);
            end
            if (bp_valid[c]) begin
                checks++;
                if (instr_pc_o !== bp_hpc[c]) begin
                    failures++;
                    $display("FAIL bp_head c=%0d got pc=%h required %h", c, instr_pc_o, bp_hpc[c]);
                end
            end
            tick();
        end
    endtask

    task automatic test_wait;
        do_reset();
        run_stream(5);
        fetch_wait_i = 1'b1;
        #1;
        checks++;
        if (fetch_en !== 1'b1 || fetch_addr !== 16'h0005 || fetch_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL wait_issue got en=%b addr=%h busy=%b required 1 0005 0",
                     fetch_en, fetch_addr, fetch_busy_o);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            fetch_wait_i = k < 2;
            mem_req_i = 1'b1;
            #1;
            checks++;
            if (fetch_en !== 1'b1 || fetch_addr !== 16'h0005 || fetch_busy_o !== 1'b1 ||
                instr_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL wait_hold k=%0d got en=%b addr=%h busy=%b valid=%b required 1 0005 1 0",
                         k, fetch_en, fetch_addr, fetch_busy_o, instr_valid_o);
            end
            tick();
        end
        mem_req_i = 1'b0;
        fetch_wait_i = 1'b0;
        #1;
        checks++;
        if (fetch_busy_o !== 1'b0 || fetch_en !== 1'b1 || fetch_addr !== 16'h0006) begin
            failures++;
            $display("FAIL wait_resume got busy=%b en=%b addr=%h required 0 1 0006",
                     fetch_busy_o, fetch_en, fetch_addr);
        end
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 16'h0005 || instr_o !== 16'hA5A0) begin
            failures++;
            $display("FAIL wait_push got valid=%b pc=%h instr=%h required 1 0005 a5a0",
                     instr_valid_o, instr_pc_o, instr_o);
        end
        tick();
    endtask

    task automatic test_discard;
        do_reset();
        run_stream(7);
        instr_ready_i = 1'b0;
        fetch_wait_i = 1'b1;
        #1;
        checks++;
        if (fetch_en !== 1'b1 || fetch_addr !== 16'h0007) begin
            failures++;
            $display("FAIL disc_issue got en=%b addr=%h required 1 0007", fetch_en, fetch_addr);
        end
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 16'h0100;
        #1;
        checks++;
        if (fetch_busy_o !== 1'b1 || fetch_addr !== 16'h0007 || instr_valid_o !== 1'b1 ||
            instr_pc_o !== 16'h0006) begin
            failures++;
            $display("FAIL disc_redirect got busy=%b addr=%h valid=%b pc=%h required 1 0007 1 0006",
                     fetch_busy_o, fetch_addr, instr_valid_o, instr_pc_o);
        end
        tick();
        redirect_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            fetch_wait_i = k == 0;
            #1;
            checks++;
            if (fetch_en !== 1'b1 || fetch_addr !== 16'h0007 || fetch_busy_o !== 1'b1 ||
                instr_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL disc_hold k=%0d got en=%b addr=%h busy=%b valid=%b required 1 0007 1 0",
                         k, fetch_en, fetch_addr, fetch_busy_o, instr_valid_o);
            end
            tick();
        end
        #1;
        checks++;
        if (fetch_en !== 1'b1 || fetch_addr !== 16'h0100 || fetch_busy_o !== 1'b0 ||
            instr_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL disc_target got en=%b addr=%h busy=%b valid=%b required 1 0100 0 0",
                     fetch_en, fetch_addr, fetch_busy_o, instr_valid_o);
        end
        tick();
        #1;
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 16'h0100 || instr_o !== 16'hA4A5) begin
            failures++;
            $display("FAIL disc_first got valid=%b pc=%h instr=%h required 1 0100 a4a5",
                     instr_valid_o, instr_pc_o, instr_o);
        end
        tick();
    endtask

    task automatic test_wrap;
        do_reset();
        redirect_i = 1'b1;
        redirect_pc_i = 16'hFFFF;
        #1;
        checks++;
        if (fetch_en !== 1'b0) begin
            failures++;
            $display("FAIL wrap_suppress got en=%b required 0", fetch_en);
        end
        tick();
        redirect_i = 1'b0;
        #1;
        checks++;
        if (fetch_en !== 1'b1 || fetch_addr !== 16'hFFFF || instr_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL wrap_top got en=%b addr=%h valid=%b required 1 ffff 0",
                     fetch_en, fetch_addr, instr_valid_o);
        end
        tick();
        #1;
        checks++;
        if (fetch_addr !== 16'h0000 || instr_pc_o !== 16'hFFFF || instr_o !== 16'h5A5A) begin
            failures++;
            $display("FAIL wrap_zero got addr=%h pc=%h instr=%h required 0000 ffff 5a5a",
                     fetch_addr, instr_pc_o, instr_o);
        end
        tick();
        #1;
        checks++;
        if (fetch_addr !== 16'h0001 || instr_pc_o !== 16'h0000 || instr_o !== 16'hA5A5) begin
            failures++;
            $display("FAIL wrap_next got addr=%h pc=%h instr=%h required 0001 0000 a5a5",
                     fetch_addr, instr_pc_o, instr_o);
        end
        tick();
    endtask

    task automatic test_memreq_flush;
        do_reset();
        instr_ready_i = 1'b0;
        mem_req_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (fetch_en !== 1'b0 || fetch_re !== 1'b0) begin
                failures++;
                $display("FAIL memreq_hold k=%0d got en=%b re=%b required 0 0", k, fetch_en, fetch_re);
            end
            tick();
        end
        mem_req_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (fetch_en !== 1'b1 || fetch_addr !== 16'(k)) begin
                failures++;
                $display("FAIL memreq_fill k=%0d got en=%b addr=%h required 1 %h",
                         k, fetch_en, fetch_addr, 16'(k));
            end
            tick();
        end
        instr_ready_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 16'h0040;
        #1;
        checks++;
        if (fetch_en !== 1'b0 || instr_valid_o !== 1'b1 || instr_pc_o !== 16'h0000) begin
            failures++;
            $display("FAIL flush_pre got en=%b valid=%b pc=%h required 0 1 0000",
                     fetch_en, instr_valid_o, instr_pc_o);
        end
        tick();
        redirect_i = 1'b0;
        #1;
        checks++;
        if (instr_valid_o !== 1'b0 || fetch_en !== 1'b1 || fetch_addr !== 16'h0040) begin
            failures++;
            $display("FAIL flush_post got valid=%b en=%b addr=%h required 0 1 0040",
                     instr_valid_o, fetch_en, fetch_addr);
        end
        tick();
        #1;
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 16'h0040) begin
            failures++;
            $display("FAIL flush_refill got valid=%b pc=%h required 1 0040", instr_valid_o, instr_pc_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_wait();
        test_discard();
        test_wrap();
        test_memreq_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
